alu_muldiv_sequencer: RTL and testbench

Multi-cycle controller that runs 32-bit unsigned multiply (low word) and unsigned divide/remainder by sequencing the shared combinational ALU, one iteration per clock. It sits beside the ALU in the execute stage. While an operation runs it owns the ALU's `alu_in_1`, `alu_in_2` and `alu_op` inputs. It returns a registered result with a `done` pulse.

---
 rtl/alu_muldiv_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned MUL (low word) / DIVU sequencer that borrows the shared
// combinational ALU for one shift-add or restoring-subtract step per clock.
module alu_muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_sel,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic [31:0] alu_in_1,
  output logic [31:0] alu_in_2,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result
);

  // Handshake: start is accepted only when idle (busy low); done pulses for
  // exactly one cycle and result_lo/result_hi stay valid until the next accept.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DIVZ = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_IDLE = 4'b1111;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [31:0] opa_q, opa_d;   // mcand (MUL) / quo (DIVU)
  logic [31:0] opb_q, opb_d;   // mplier (MUL) / div (DIVU)
  logic [31:0] acc_q, acc_d;   // acc (MUL) / rem (DIVU)
  logic [31:0] res_lo_q, res_lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic        busy_q, done_q;

  logic [31:0] shifted;
  logic        take;

  assign shifted = {acc_q[30:0], opa_q[31]};
  // rem[31] shifted out means the true partial remainder exceeds 32 bits.
  assign take    = acc_q[31] | (shifted >= opb_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    alu_in_1 = 32'd0;
    alu_in_2 = 32'd0;
    alu_op   = ALU_IDLE;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op_sel;
          cnt_d = 5'd0;
          opa_d = operand_a;
          opb_d = operand_b;
          acc_d = 32'd0;
          state_d = (op_sel && operand_b == 32'd0) ? S_DIVZ : S_STEP;
        end
      end
      S_STEP: begin
        cnt_d = cnt_q + 5'd1;
        if (!op_q) begin
          alu_in_1 = acc_q;
          alu_in_2 = opa_q;
          alu_op   = ALU_ADD;
          if (opb_q[0]) acc_d = alu_result;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          alu_in_1 = shifted;
          alu_in_2 = opb_q;
          alu_op   = ALU_SUB;
          acc_d    = take ? alu_result : shifted;
          opa_d    = {opa_q[30:0], take};
        end
        if (cnt_q == 5'd31) begin
          state_d  = S_DONE;
          res_lo_d = op_q ? opa_d : acc_d;
          res_hi_d = op_q ? acc_d : 32'd0;
        end
      end
      S_DIVZ: begin
        state_d  = S_DONE;
        res_lo_d = 32'hFFFF_FFFF;
        res_hi_d = opa_q;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 1'b0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      acc_q    <= 32'd0;
      res_lo_q <= 32'd0;
      res_hi_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed bench for alu_muldiv_sequencer: behavioural ALU, expected-result
// queue filled at accept and drained on done, timing and ALU-ownership checks.
module tb_alu_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op_sel;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic [31:0] alu_in_1;
  logic [31:0] alu_in_2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  alu_muldiv_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op_sel     (op_sel),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .done       (done),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .alu_in_1   (alu_in_1),
    .alu_in_2   (alu_in_2),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  // Shared ALU stand-in: add / subtract, anything else returns 0.
  assign alu_result = (alu_op == 4'b0000) ? alu_in_1 + alu_in_2 :
                      (alu_op == 4'b0001) ? alu_in_1 - alu_in_2 : 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (!op) return {32'd0, a * b};
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation from accept to the cycle after done. With poke set,
  // start is re-pulsed at E10 and during DONE, both of which must be ignored.
  task automatic do_op(input string tag, input logic op, input logic [31:0] a,
                       input logic [31:0] b, input bit poke);
    logic [63:0] e;
    logic [3:0]  want_op;
    int cyc, alu_n, bad_op, bad_busy;
    bit seen;
    @(negedge clk);
    op_sel = op; operand_a = a; operand_b = b; start = 1'b1;
    exp_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom; op_sel = 1'($urandom_range(0, 1));
    want_op = op ? 4'b0001 : 4'b0000;
    cyc = 0; alu_n = 0; bad_op = 0; bad_busy = 0; seen = 0;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      if (poke) begin
        if (cyc == 10) begin
          start = 1'b1; operand_a = 32'd99; operand_b = 32'd98;
        end else if (cyc == 11) start = 1'b0;
      end
      if (done === 1'b1) seen = 1;
      else begin
        if (busy !== 1'b1) bad_busy++;
        if (alu_op !== 4'b1111) begin
          alu_n++;
          if (alu_op !== want_op) bad_op++;
        end
      end
    end
    e = exp_q.pop_front();
    check({tag, " done_cycle"}, 64'(cyc), (op && b == 32'd0) ? 64'd2 : 64'd33);
    check({tag, " result"}, {result_hi, result_lo}, e);
    check({tag, " busy_at_done"}, 64'(busy), 64'd1);
    check({tag, " step_cycles"}, 64'(alu_n), (op && b == 32'd0) ? 64'd0 : 64'd32);
    check({tag, " alu_op_steps"}, 64'(bad_op), 64'd0);
    check({tag, " busy_while_running"}, 64'(bad_busy), 64'd0);
    if (poke) begin
      start = 1'b1; operand_a = 32'd77; operand_b = 32'd5;
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    check({tag, " alu_idle"}, {28'd0, alu_op, alu_in_1 | alu_in_2}, {28'd0, 4'b1111, 32'd0});
    check({tag, " result_held"}, {result_hi, result_lo}, e);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_sel = 1'b0; operand_a = '0; operand_b = '0;
    #2;
    check("reset_outputs", {62'd0, busy, done}, 64'd0);
    check("reset_results", {result_hi, result_lo}, 64'd0);
    check("reset_alu", {28'd0, alu_op, alu_in_1 | alu_in_2}, {28'd0, 4'b1111, 32'd0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    do_op("mul_7x6",     1'b0, 32'd7,          32'd6,          1'b0);
    do_op("mul_max",     1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0);
    do_op("mul_wrap",    1'b0, 32'h8000_0000,  32'd2,          1'b0);
    do_op("divu_100_7",  1'b1, 32'd100,        32'd7,          1'b0);
    do_op("divu_max_1",  1'b1, 32'hFFFF_FFFF,  32'd1,          1'b0);
    do_op("divu_5_9",    1'b1, 32'd5,          32'd9,          1'b0);
    do_op("divu_5_0",    1'b1, 32'd5,          32'd0,          1'b0);
    do_op("mul_3x4_ign", 1'b0, 32'd3,          32'd4,          1'b1);
    for (int i = 0; i < 4; i++) begin
      do_op("rand_op", 1'(i), $urandom, $urandom_range(1, 32'hFFFF), 1'b0);
    end

    // Reset in the middle of DIVU 1000/3 must abort without a done pulse.
    @(negedge clk);
    op_sel = 1'b1; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
    exp_q.push_back(model(1'b1, 32'd1000, 32'd3));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_outputs", {62'd0, busy, done}, 64'd0);
    check("abort_results", {result_hi, result_lo}, 64'd0);
    check("abort_alu", {28'd0, alu_op, alu_in_1 | alu_in_2}, {28'd0, 4'b1111, 32'd0});
    void'(exp_q.pop_back());
    @(negedge clk);
    check("abort_no_done", 64'(done), 64'd0);
    reset = 1'b0;
    do_op("divu_9_2", 1'b1, 32'd9, 32'd2, 1'b0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
